// File: rtl/pong_score_ctrl.sv
// Pong game-control FSM and two-player 2-digit BCD scoreboard feeding the text overlay.
// Every output comes straight from a flop; next values are decoded from the next state.
module pong_score_ctrl #(
  parameter int WIN_SCORE   = 7,
  parameter int PAUSE_TICKS = 120
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       refr_tick,
  input  logic       btn,
  input  logic       p1_point,
  input  logic       p2_point,
  output logic [3:0] dig0,
  output logic [3:0] dig1,
  output logic [3:0] dig2,
  output logic [3:0] dig3,
  output logic [1:0] ball,
  output logic       gra_still,
  output logic [1:0] state
);

  localparam logic [7:0] WIN_BCD = {4'(WIN_SCORE / 10), 4'(WIN_SCORE % 10)};
  localparam logic [6:0] PAUSE   = 7'(PAUSE_TICKS);

  typedef enum logic [1:0] {NEWGAME = 2'b00, PLAY = 2'b01, NEWBALL = 2'b10, OVER = 2'b11} state_t;

  state_t     st_q, st_d;
  logic [6:0] timer_q, timer_d;
  logic [7:0] p1_q, p1_d, p2_q, p2_d;   // {tens, ones}
  logic [1:0] ball_q, ball_d;
  logic       still_q, still_d;
  logic [7:0] p1_inc, p2_inc;
  logic       p1_win, p2_win, timer_up, p1_only, p2_only;

  // Saturating BCD +1; 99 stays 99 so digits can never leave 0..9.
  function automatic logic [7:0] bcd_inc(input logic [7:0] s);
    if (s == 8'h99)       return s;
    if (s[3:0] >= 4'd9)   return {s[7:4] + 4'd1, 4'd0};
    return {s[7:4], s[3:0] + 4'd1};
  endfunction

  assign p1_inc   = bcd_inc(p1_q);
  assign p2_inc   = bcd_inc(p2_q);
  assign p1_win   = (p1_inc == WIN_BCD);
  assign p2_win   = (p2_inc == WIN_BCD);
  assign timer_up = (timer_q == 7'd0);
  assign p1_only  = p1_point & ~p2_point;
  assign p2_only  = p2_point & ~p1_point;

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q    <= NEWGAME;
      timer_q <= 7'd0;
      p1_q    <= 8'h00;
      p2_q    <= 8'h00;
      ball_q  <= 2'b00;
      still_q <= 1'b1;
    end else begin
      st_q    <= st_d;
      timer_q <= timer_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
      ball_q  <= ball_d;
      still_q <= still_d;
    end
  end

  always_comb begin
    st_d = st_q;
    case (st_q)
      NEWGAME: if (btn) st_d = PLAY;
      PLAY: begin
        if (p1_point && p2_point) st_d = NEWBALL;
        else if (p1_only)         st_d = p1_win ? OVER : NEWBALL;
        else if (p2_only)         st_d = p2_win ? OVER : NEWBALL;
      end
      NEWBALL: if (timer_up) st_d = PLAY;
      OVER:    if (timer_up && btn) st_d = NEWGAME;
      default: st_d = NEWGAME;
    endcase
  end

  always_comb begin
    p1_d    = p1_q;
    p2_d    = p2_q;
    ball_d  = ball_q;
    still_d = (st_d != PLAY);
    // Pause load wins over the tick so every pause is exactly PAUSE_TICKS frames.
    if (st_d != st_q && (st_d == NEWBALL || st_d == OVER)) timer_d = PAUSE;
    else if (refr_tick && !timer_up)                       timer_d = timer_q - 7'd1;
    else                                                   timer_d = timer_q;
    case (st_q)
      NEWGAME: if (btn) ball_d = 2'b01;
      PLAY: begin
        if (p1_only) begin
          p1_d   = p1_inc;
          ball_d = p1_win ? 2'b00 : 2'b10;
        end else if (p2_only) begin
          p2_d   = p2_inc;
          ball_d = p2_win ? 2'b00 : 2'b01;
        end
      end
      OVER: if (timer_up && btn) begin
        p1_d   = 8'h00;
        p2_d   = 8'h00;
        ball_d = 2'b00;
      end
      default: ;
    endcase
  end

  assign dig0      = p1_q[3:0];
  assign dig1      = p1_q[7:4];
  assign dig2      = p2_q[3:0];
  assign dig3      = p2_q[7:4];
  assign ball      = ball_q;
  assign gra_still = still_q;
  assign state     = st_q;

endmodule

// File: tb/tb_pong_score_ctrl.sv
// Bench for pong_score_ctrl: vector table, directed corner sequences and random play
// against an integer-score reference model, on a WIN_SCORE=7 and a WIN_SCORE=15 instance.
module tb_pong_score_ctrl;
  localparam int PT = 120;

  logic clk = 1'b0;
  logic reset, refr_tick, btn, p1_point, p2_point;
  logic [3:0] a_d0, a_d1, a_d2, a_d3, b_d0, b_d1, b_d2, b_d3;
  logic [1:0] a_ball, a_state, b_ball, b_state;
  logic       a_still, b_still;

  int checks = 0;
  int errors = 0;

  pong_score_ctrl #(.WIN_SCORE(7), .PAUSE_TICKS(PT)) u_a (
    .clk(clk), .reset(reset), .refr_tick(refr_tick), .btn(btn),
    .p1_point(p1_point), .p2_point(p2_point),
    .dig0(a_d0), .dig1(a_d1), .dig2(a_d2), .dig3(a_d3),
    .ball(a_ball), .gra_still(a_still), .state(a_state));

  pong_score_ctrl #(.WIN_SCORE(15), .PAUSE_TICKS(PT)) u_b (
    .clk(clk), .reset(reset), .refr_tick(refr_tick), .btn(btn),
    .p1_point(p1_point), .p2_point(p2_point),
    .dig0(b_d0), .dig1(b_d1), .dig2(b_d2), .dig3(b_d3),
    .ball(b_ball), .gra_still(b_still), .state(b_state));

  always #5 clk = ~clk;

  // Reference: scores as plain integers, states 0 NEWGAME 1 PLAY 2 NEWBALL 3 OVER.
  typedef struct {int st; int p1; int p2; int ball; int tmr;} mdl_t;
  mdl_t ma, mb;

  function automatic mdl_t step(mdl_t m, int win, bit rst, bit rt, bit bt, bit q1, bit q2);
    mdl_t n = m;
    if (rst) begin
      n.st = 0; n.p1 = 0; n.p2 = 0; n.ball = 0; n.tmr = 0;
      return n;
    end
    case (m.st)
      0: if (bt) begin n.st = 1; n.ball = 1; end
      1: begin
        if (q1 && q2) n.st = 2;
        else if (q1) begin
          n.p1 = (m.p1 + 1 > 99) ? 99 : m.p1 + 1;
          n.ball = 2; n.st = 2;
          if (n.p1 == win) begin n.st = 3; n.ball = 0; end
        end else if (q2) begin
          n.p2 = (m.p2 + 1 > 99) ? 99 : m.p2 + 1;
          n.ball = 1; n.st = 2;
          if (n.p2 == win) begin n.st = 3; n.ball = 0; end
        end
      end
      2: if (m.tmr == 0) n.st = 1;
      default: if (m.tmr == 0 && bt) begin n.st = 0; n.p1 = 0; n.p2 = 0; n.ball = 0; end
    endcase
    if (n.st != m.st && (n.st == 2 || n.st == 3)) n.tmr = PT;
    else if (rt && m.tmr > 0) n.tmr = m.tmr - 1;
    return n;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_model(input string nm, input mdl_t m, input logic [1:0] st,
                           input logic [3:0] d0, input logic [3:0] d1, input logic [3:0] d2,
                           input logic [3:0] d3, input logic [1:0] bl, input logic still);
    logic [20:0] act, exp;
    act = {st, d3, d2, d1, d0, bl, still};
    exp = {2'(m.st), 4'(m.p2 / 10), 4'(m.p2 % 10), 4'(m.p1 / 10), 4'(m.p1 % 10),
           2'(m.ball), 1'(m.st != 1)};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s model: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(input bit rst, input bit rt, input bit bt, input bit q1, input bit q2);
    reset = rst; refr_tick = rt; btn = bt; p1_point = q1; p2_point = q2;
    @(posedge clk);
    ma = step(ma, 7, rst, rt, bt, q1, q2);
    mb = step(mb, 15, rst, rt, bt, q1, q2);
    #1;
    cmp_model("dut_a", ma, a_state, a_d0, a_d1, a_d2, a_d3, a_ball, a_still);
    cmp_model("dut_b", mb, b_state, b_d0, b_d1, b_d2, b_d3, b_ball, b_still);
  endtask

  // Tick until neither instance is pausing between serves; bounded.
  task automatic wait_nb();
    int n = 0;
    while ((ma.st == 2 || mb.st == 2) && n < 400) begin
      cyc(0, 1, 0, 0, 0);
      n++;
    end
    if (n == 400) begin
      checks++; errors++;
      $display("FAIL wait_nb: timeout after %0d cycles", n);
    end
  endtask

  typedef struct {bit rst, rt, bt, q1, q2; int st, p1, p2, ball, still;} vec_t;
  vec_t tbl[10];

  initial begin
    ma = '{0, 0, 0, 0, 0};
    mb = '{0, 0, 0, 0, 0};
    tbl[0] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    tbl[1] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    tbl[2] = '{0, 0, 1, 0, 0, 1, 0, 0, 1, 0};
    tbl[3] = '{0, 0, 0, 1, 0, 2, 1, 0, 2, 1};
    tbl[4] = '{0, 0, 0, 0, 1, 2, 1, 0, 2, 1};
    tbl[5] = '{0, 0, 1, 0, 0, 2, 1, 0, 2, 1};
    tbl[6] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    tbl[7] = '{0, 0, 1, 0, 0, 1, 0, 0, 1, 0};
    tbl[8] = '{0, 0, 0, 1, 1, 2, 0, 0, 1, 1};
    tbl[9] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 1};

    // Reset then 10 idle cycles
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, 0);
    chk("idle_state", a_state, 0);
    chk("idle_still", a_still, 1);

    for (int i = 0; i < 10; i++) begin
      cyc(tbl[i].rst, tbl[i].rt, tbl[i].bt, tbl[i].q1, tbl[i].q2);
      chk($sformatf("tbl%0d_state", i), a_state, tbl[i].st);
      chk($sformatf("tbl%0d_p1", i), int'(a_d1) * 10 + int'(a_d0), tbl[i].p1);
      chk($sformatf("tbl%0d_p2", i), int'(a_d3) * 10 + int'(a_d2), tbl[i].p2);
      chk($sformatf("tbl%0d_ball", i), a_ball, tbl[i].ball);
      chk($sformatf("tbl%0d_still", i), a_still, tbl[i].still);
    end

    // Pause length with btn held: 120 ticks, then PLAY one cycle later
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 1, 0);
    for (int i = 0; i < 119; i++) cyc(0, 1, 1, 0, 0);
    chk("pause_119", a_state, 2);
    cyc(0, 1, 1, 0, 0);
    chk("pause_120", a_state, 2);
    cyc(0, 0, 1, 0, 0);
    chk("pause_expire", a_state, 1);

    // P1 to 7 on the default instance, then game-over hold and restart
    for (int k = 0; k < 6; k++) begin
      cyc(0, 0, 0, 1, 0);
      if (k < 5) wait_nb();
    end
    chk("win7_state", a_state, 3);
    chk("win7_ball", a_ball, 0);
    chk("win7_dig0", a_d0, 7);
    for (int t = 1; t <= 120; t++) begin
      cyc(0, 1, t >= 50, 0, 0);
      if (t == 50) chk("over_btn_early", a_state, 3);
    end
    chk("over_expired", a_state, 3);
    cyc(0, 0, 1, 0, 0);
    chk("restart_state", a_state, 0);
    chk("restart_digits", {a_d3, a_d2, a_d1, a_d0}, 0);

    // P2 crossing the BCD tens boundary up to WIN_SCORE=15
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    for (int k = 1; k <= 15; k++) begin
      cyc(0, 0, 0, 0, 1);
      if (k == 9)  chk("p2_9", {b_d3, b_d2}, 8'h09);
      if (k == 10) chk("p2_10", {b_d3, b_d2}, 8'h10);
      if (k < 15) wait_nb();
    end
    chk("win15_state", b_state, 3);
    chk("win15_ball", b_ball, 0);
    chk("win15_digits", {b_d3, b_d2}, 8'h15);

    // Reset in NEWBALL with timer at 60 and P1 = 3
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, 0, 1, 0);
      if (k < 2) wait_nb();
    end
    for (int i = 0; i < 60; i++) cyc(0, 1, 0, 0, 0);
    chk("mid_pre_state", a_state, 2);
    chk("mid_pre_p1", a_d0, 3);
    cyc(1, 0, 0, 0, 0);
    chk("mid_rst_state", a_state, 0);
    chk("mid_rst_digits", {a_d3, a_d2, a_d1, a_d0}, 0);
    chk("mid_rst_still", a_still, 1);
    cyc(0, 0, 1, 0, 0);
    chk("mid_rst_play", a_state, 1);

    // Random play against the model
    for (int i = 0; i < 6000; i++)
      cyc($urandom_range(0, 499) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
          $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
